// File: rtl/obstacle_scroller_if.sv
// Signal bundle between the game-speed/control side and the obstacle scroller.
// The scroller takes the slave view; the bench or surrounding game logic takes the master view.
interface obstacle_scroller_if #(
    parameter int N_OBS = 3,
    parameter int X_W   = 10
);
    logic                   clk_div;
    logic                   start;
    logic                   hit;
    logic [N_OBS*X_W-1:0]   obs_x;
    logic [N_OBS-1:0]       obs_valid;
    logic [N_OBS-1:0]       obs_type;
    logic [1:0]             pass_cnt;
    logic [1:0]             state;

    modport master (
        output clk_div,
        output start,
        output hit,
        input  obs_x,
        input  obs_valid,
        input  obs_type,
        input  pass_cnt,
        input  state
    );

    modport slave (
        input  clk_div,
        input  start,
        input  hit,
        output obs_x,
        output obs_valid,
        output obs_type,
        output pass_cnt,
        output state
    );
endinterface

// File: rtl/obstacle_scroller.sv
// Obstacle scroller: turns each clk_div rising edge into a game tick, scrolls the obstacle
// slots left, retires those leaving the screen and spawns new ones at LFSR-driven gaps.
module obstacle_scroller #(
    parameter int          N_OBS      = 3,
    parameter int          X_W        = 10,
    parameter int          X_START    = 640,
    parameter int          STEP       = 1,
    parameter int          MIN_GAP    = 40,
    parameter int          GAP_RAND_W = 6,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    obstacle_scroller_if.slave  bus
);

    localparam int              GAP_W     = $clog2(MIN_GAP + (1 << GAP_RAND_W));
    localparam logic [15:0]     LFSR_MASK = 16'hB400;
    localparam logic [X_W-1:0]  X_SPAWN   = X_W'(X_START);
    localparam logic [X_W-1:0]  X_STEP    = X_W'(STEP);
    localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(MIN_GAP);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FROZEN = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic               w_clear;
    logic               w_advance;

    logic               r_clkDivQ;
    logic               w_tick;

    logic [X_W-1:0]     r_x [N_OBS];
    logic [N_OBS-1:0]   r_valid;
    logic [N_OBS-1:0]   r_type;
    logic [1:0]         r_passCnt;
    logic [GAP_W-1:0]   r_gapCnt;
    logic [GAP_W-1:0]   r_gapTarget;
    logic [15:0]        r_lfsr;

    logic [X_W-1:0]     w_xNext [N_OBS];
    logic [N_OBS-1:0]   w_validNext;
    logic [N_OBS-1:0]   w_typeNext;
    logic [1:0]         w_passNext;
    logic [GAP_W-1:0]   w_gapCntNext;
    logic [GAP_W-1:0]   w_gapTargetNext;
    logic [15:0]        w_lfsrNext;
    logic [GAP_W-1:0]   w_gapInc;
    logic               w_gapDue;
    logic               w_spawn;
    logic               w_haveFree;
    logic [1:0]         w_freeSlot;
    logic [N_OBS*X_W-1:0] w_obsX;

    // clk_div_q resets high so a clk_div already high at reset release is not seen as an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkDivQ <= 1'b1;
        end else begin
            r_clkDivQ <= bus.clk_div;
        end
    end

    assign w_tick = bus.clk_div & ~r_clkDivQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // start restarts from any state; hit in RUN beats a same-cycle tick
    always_comb begin
        w_stateNext = r_state;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_stateNext = RUN;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                if (bus.start) begin
                    w_clear = 1'b1;
                end else if (bus.hit) begin
                    w_stateNext = FROZEN;
                end else begin
                    w_advance = w_tick;
                end
            end
            FROZEN: begin
                if (bus.start) begin
                    w_stateNext = RUN;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        w_haveFree = 1'b0;
        w_freeSlot = 2'd0;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_haveFree = 1'b1;
                w_freeSlot = 2'(i);
            end
        end
    end

    assign w_gapInc = r_gapCnt + GAP_W'(1);
    assign w_gapDue = (w_gapInc >= r_gapTarget);
    assign w_spawn  = w_gapDue & w_haveFree;

    // Every tick decision works on pre-tick slot state, so a slot freed now is reused next tick
    always_comb begin
        w_xNext         = r_x;
        w_validNext     = r_valid;
        w_typeNext      = r_type;
        w_passNext      = 2'd0;
        w_gapCntNext    = r_gapCnt;
        w_gapTargetNext = r_gapTarget;
        w_lfsrNext      = r_lfsr;
        if (w_clear) begin
            for (int i = 0; i < N_OBS; i++) begin
                w_xNext[i] = '0;
            end
            w_validNext     = '0;
            w_typeNext      = '0;
            w_gapCntNext    = '0;
            w_gapTargetNext = GAP_MIN;
        end else if (w_advance) begin
            for (int i = 0; i < N_OBS; i++) begin
                if (r_valid[i]) begin
                    if (r_x[i] < X_STEP) begin
                        w_validNext[i] = 1'b0;
                        w_passNext     = w_passNext + 2'd1;
                    end else begin
                        w_xNext[i] = r_x[i] - X_STEP;
                    end
                end else if (w_spawn && (2'(i) == w_freeSlot)) begin
                    w_xNext[i]     = X_SPAWN;
                    w_validNext[i] = 1'b1;
                    w_typeNext[i]  = r_lfsr[0];
                end
            end
            if (w_spawn) begin
                w_gapCntNext    = '0;
                w_gapTargetNext = GAP_MIN + GAP_W'(r_lfsr[GAP_RAND_W:1]);
            end else if (w_gapDue) begin
                w_gapCntNext = r_gapTarget;
            end else begin
                w_gapCntNext = w_gapInc;
            end
            w_lfsrNext = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // Datapath registers; pass count is a one-cycle pulse value, zero whenever no tick lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_OBS; i++) begin
                r_x[i] <= '0;
            end
            r_valid     <= '0;
            r_type      <= '0;
            r_passCnt   <= 2'd0;
            r_gapCnt    <= '0;
            r_gapTarget <= GAP_MIN;
            r_lfsr      <= LFSR_SEED;
        end else begin
            for (int i = 0; i < N_OBS; i++) begin
                r_x[i] <= w_xNext[i];
            end
            r_valid     <= w_validNext;
            r_type      <= w_typeNext;
            r_passCnt   <= w_passNext;
            r_gapCnt    <= w_gapCntNext;
            r_gapTarget <= w_gapTargetNext;
            r_lfsr      <= w_lfsrNext;
        end
    end

    always_comb begin
        w_obsX = '0;
        for (int i = 0; i < N_OBS; i++) begin
            w_obsX[i*X_W +: X_W] = r_x[i];
        end
    end

    assign bus.obs_x     = w_obsX;
    assign bus.obs_valid = r_valid;
    assign bus.obs_type  = r_type;
    assign bus.pass_cnt  = r_passCnt;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: expected values are queued as stimulus is applied
// and popped against the DUT outputs, using a small LFSR model for spawn types and gaps.
module tb_obstacle_scroller;

    localparam int N_OBS = 3;
    localparam int X_W   = 10;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbQ[$];
    logic [15:0] mLfsr;
    logic [15:0] lastPre;
    logic [15:0] p40;
    logic [15:0] p2;
    bit          mRun;
    int          tickNum;
    int          g1;
    int          g2;
    int          t1;
    int          t2;
    logic [29:0] expX;

    always #5 clk = ~clk;

    obstacle_scroller_if #(.N_OBS(N_OBS), .X_W(X_W)) bus ();

    obstacle_scroller #(
        .N_OBS      (N_OBS),
        .X_W        (X_W),
        .X_START    (640),
        .STEP       (1),
        .MIN_GAP    (40),
        .GAP_RAND_W (6),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] lfsrStep(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic expectVal(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [63:0] observed);
        exp_t e;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty got %0h exp none", observed);
        end else begin
            e = sbQ.pop_front();
            assert (observed === e.exp) else begin
                errors++;
                $display("[TB] FAIL %s got %0h exp %0h", e.tag, observed, e.exp);
                $error("[TB] check %s did not match", e.tag);
            end
        end
    endtask

    // Rising half of a clk_div period; the model LFSR steps once per tick while running
    task automatic tickRise();
        @(negedge clk);
        bus.clk_div = 1'b1;
        lastPre = mLfsr;
        if (mRun) begin
            mLfsr = lfsrStep(mLfsr);
            tickNum++;
        end
        @(negedge clk);
    endtask

    task automatic tickFall();
        @(negedge clk);
        bus.clk_div = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int nTicks);
        repeat (nTicks) begin
            tickRise();
            tickFall();
        end
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        mRun = 1'b1;
        tickNum = 0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.clk_div = 1'b1;
        bus.start   = 1'b0;
        bus.hit     = 1'b0;
        mLfsr       = 16'hACE1;
        lastPre     = 16'hACE1;
        mRun        = 1'b0;
        tickNum     = 0;
        repeat (3) @(negedge clk);

        expectVal("rst_state", 64'd0);  checkOutput(64'(bus.state));
        expectVal("rst_valid", 64'd0);  checkOutput(64'(bus.obs_valid));
        expectVal("rst_x", 64'd0);      checkOutput(64'(bus.obs_x));
        expectVal("rst_pass", 64'd0);   checkOutput(64'(bus.pass_cnt));

        rst = 1'b0;
        tickFall();
        pulseStart();
        expectVal("start_state", 64'd1); checkOutput(64'(bus.state));
        expectVal("start_valid", 64'd0); checkOutput(64'(bus.obs_valid));

        // First spawn lands on tick 40 with type from the LFSR after 39 steps
        expectVal("valid_t39", 64'd0);
        applyStimulus(39);
        checkOutput(64'(bus.obs_valid));
        applyStimulus(1);
        p40 = lastPre;
        expectVal("valid_t40", 64'd1);   checkOutput(64'(bus.obs_valid));
        expectVal("x0_t40", 64'd640);    checkOutput(64'(bus.obs_x[9:0]));
        expectVal("type0_t40", 64'(p40[0])); checkOutput(64'(bus.obs_type[0]));

        g1 = 40 + int'(p40[6:1]);
        expectVal("valid_gap_minus1", 64'd1);
        applyStimulus(g1 - 1);
        checkOutput(64'(bus.obs_valid));
        applyStimulus(1);
        t1 = tickNum;
        p2 = lastPre;
        g2 = 40 + int'(p2[6:1]);
        t2 = t1 + g2;
        expectVal("valid_second_spawn", 64'd3); checkOutput(64'(bus.obs_valid));

        // All slots full long before slot0 reaches x=0 at tick 680
        applyStimulus(680 - tickNum);
        expectVal("valid_t680", 64'd7);  checkOutput(64'(bus.obs_valid));
        expectVal("x0_t680", 64'd0);     checkOutput(64'(bus.obs_x[9:0]));

        tickRise();
        expectVal("retire_valid", 64'd6); checkOutput(64'(bus.obs_valid));
        expectVal("retire_pass", 64'd1);  checkOutput(64'(bus.pass_cnt));
        @(negedge clk);
        expectVal("pass_one_cycle", 64'd0); checkOutput(64'(bus.pass_cnt));
        bus.clk_div = 1'b0;
        @(negedge clk);

        applyStimulus(1);
        expectVal("respawn_valid", 64'd7); checkOutput(64'(bus.obs_valid));
        expectVal("respawn_x0", 64'd640);  checkOutput(64'(bus.obs_x[9:0]));
        expectVal("respawn_type0", 64'(lastPre[0])); checkOutput(64'(bus.obs_type[0]));

        expX = {10'(640 - (682 - t2)), 10'(640 - (682 - t1)), 10'd640};

        // hit together with a tick: frozen without movement
        @(negedge clk);
        bus.clk_div = 1'b1;
        bus.hit     = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
        expectVal("freeze_state", 64'd2); checkOutput(64'(bus.state));
        expectVal("freeze_x", 64'(expX)); checkOutput(64'(bus.obs_x));
        tickFall();
        mRun = 1'b0;
        applyStimulus(100);
        expectVal("frozen_x_100", 64'(expX)); checkOutput(64'(bus.obs_x));
        expectVal("frozen_state_100", 64'd2); checkOutput(64'(bus.state));
        expectVal("frozen_valid_100", 64'd7); checkOutput(64'(bus.obs_valid));

        pulseStart();
        expectVal("restart_valid", 64'd0); checkOutput(64'(bus.obs_valid));
        expectVal("restart_state", 64'd1); checkOutput(64'(bus.state));
        expectVal("restart_valid_t39", 64'd0);
        applyStimulus(39);
        checkOutput(64'(bus.obs_valid));
        applyStimulus(1);
        expectVal("restart_valid_t40", 64'd1); checkOutput(64'(bus.obs_valid));
        expectVal("restart_type0", 64'(lastPre[0])); checkOutput(64'(bus.obs_type[0]));

        // Asynchronous reset between clock edges
        @(negedge clk);
        bus.clk_div = 1'b1;
        #2 rst = 1'b1;
        #1;
        expectVal("async_rst_state", 64'd0); checkOutput(64'(bus.state));
        expectVal("async_rst_valid", 64'd0); checkOutput(64'(bus.obs_valid));
        expectVal("async_rst_x", 64'd0);     checkOutput(64'(bus.obs_x));
        @(negedge clk);
        rst   = 1'b0;
        mLfsr = 16'hACE1;
        mRun  = 1'b0;
        repeat (3) @(negedge clk);
        pulseStart();
        tickFall();
        applyStimulus(40);
        expectVal("reseed_valid_t40", 64'd1);   checkOutput(64'(bus.obs_valid));
        expectVal("reseed_x0_t40", 64'd640);    checkOutput(64'(bus.obs_x[9:0]));
        expectVal("reseed_type0", 64'(p40[0])); checkOutput(64'(bus.obs_type[0]));

        // One rising edge then a long static high: exactly one step
        tickRise();
        repeat (1000) @(negedge clk);
        expectVal("static_high_x0", 64'd639); checkOutput(64'(bus.obs_x[9:0]));
        tickFall();
        tickRise();
        expectVal("next_edge_x0", 64'd638); checkOutput(64'(bus.obs_x[9:0]));
        tickFall();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
